// File: rtl/dense_layer_mac.sv
// Fully-connected layer stage: one shared signed multiplier walks every weight,
// accumulating each neuron in turn, then adds bias, applies ReLU and saturates.
module dense_layer_mac #(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 8,
  parameter int W        = 8,
  parameter int FRAC     = 4,
  parameter int ACC_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [IN_SIZE*W-1:0]          x_in,
  input  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in,
  input  logic                         weights_valid,
  input  logic [OUT_SIZE*W-1:0]         bias_in,
  input  logic                         bias_valid,
  output logic [OUT_SIZE*W-1:0]         data_out,
  output logic                         busy,
  output logic                         done
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int WI = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(IN_SIZE - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT_SIZE - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (W - 1)) - 1);
  localparam logic [W-1:0] Y_MAX_W = W'((1 << (W - 1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [IN_SIZE*W-1:0]     x_q, x_d;
  logic [IW-1:0]            i_q, i_d;
  logic [OW-1:0]            o_q, o_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [W-1:0]             y_q [OUT_SIZE];
  logic [W-1:0]             y_d [OUT_SIZE];

  logic signed [W-1:0]      x_arr [IN_SIZE];
  logic signed [W-1:0]      w_arr [IN_SIZE*OUT_SIZE];
  logic signed [W-1:0]      b_arr [OUT_SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < IN_SIZE; gi++) begin : g_x
      assign x_arr[gi] = x_q[gi*W +: W];
    end
    for (gi = 0; gi < IN_SIZE * OUT_SIZE; gi++) begin : g_w
      assign w_arr[gi] = weights_in[gi*W +: W];
    end
    for (gi = 0; gi < OUT_SIZE; gi++) begin : g_b
      assign b_arr[gi]           = bias_in[gi*W +: W];
      assign data_out[gi*W +: W] = y_q[gi];
    end
  endgenerate

  logic [WI-1:0]           w_idx;
  logic signed [W-1:0]     x_sel, w_sel, b_sel;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, r;

  assign w_idx    = WI'(o_q) * WI'(IN_SIZE) + WI'(i_q);
  assign x_sel    = x_arr[i_q];
  assign w_sel    = w_arr[w_idx];
  assign b_sel    = b_arr[o_q];
  assign prod     = x_sel * w_sel;
  assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
  // Bias is moved onto the product's 2*FRAC fractional grid before accumulation.
  assign bias_ext = {{(ACC_W-W){b_sel[W-1]}}, b_sel} << FRAC;
  assign r        = acc_q >>> FRAC;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (weights_valid && bias_valid) state_d = S_LOAD;
      S_LOAD:  state_d = S_MAC;
      S_MAC:   if (i_q == I_LAST) state_d = S_WRITE;
      S_WRITE: state_d = (o_q == O_LAST) ? S_DONE : S_LOAD;
      S_DONE:  if (start) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    i_d   = i_q;
    o_d   = o_q;
    acc_d = acc_q;
    y_d   = y_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) x_d = x_in;
      S_WAIT:  o_d = '0;
      S_LOAD: begin
        acc_d = bias_ext;
        i_d   = '0;
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        i_d   = i_q + IW'(1);
      end
      S_WRITE: begin
        if (r[ACC_W-1])      y_d[o_q] = '0;
        else if (r > Y_MAX)  y_d[o_q] = Y_MAX_W;
        else                 y_d[o_q] = r[W-1:0];
        if (o_q != O_LAST) o_d = o_q + OW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      i_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < OUT_SIZE; k++) y_q[k] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      i_q     <= i_d;
      o_q     <= o_d;
      acc_q   <= acc_d;
      for (int k = 0; k < OUT_SIZE; k++) y_q[k] <= y_d[k];
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Scoreboard bench for dense_layer_mac: stimulus pushes expected result and done
// edge; a monitor pops and compares on every rising done.
module tb_dense_layer_mac;
  localparam int IN = 8;
  localparam int OUT = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, start, weights_valid, bias_valid, busy, done;
  logic [IN*W-1:0]     x_in;
  logic [IN*OUT*W-1:0] weights_in;
  logic [OUT*W-1:0]    bias_in, data_out;

  always #5 clk = ~clk;

  dense_layer_mac #(.IN_SIZE(IN), .OUT_SIZE(OUT), .W(W), .FRAC(4), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .weights_in(weights_in), .weights_valid(weights_valid),
    .bias_in(bias_in), .bias_valid(bias_valid),
    .data_out(data_out), .busy(busy), .done(done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT*W-1:0] data;
    int               done_edge;
    string            name;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_vec(string name, logic [OUT*W-1:0] act, logic [OUT*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [OUT*W-1:0] rep_out(logic [W-1:0] v);
    logic [OUT*W-1:0] r;
    for (int k = 0; k < OUT; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [IN*W-1:0] rep_in(logic [W-1:0] v);
    logic [IN*W-1:0] r;
    for (int k = 0; k < IN; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Monitor: compare result and done timing whenever done rises.
  logic done_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at edge %0d required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check_vec({mon_e.name, "_data"}, data_out, mon_e.data);
        check_int({mon_e.name, "_done_edge"}, cyc, mon_e.done_edge);
        $display("run %s: data_out=%h done at edge %0d", mon_e.name, data_out, cyc);
      end
    end
    done_prev = done;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses start for one cycle; returns the edge index that samples it.
  task automatic pulse_start(output int s);
    s = cyc + 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_exp(string name, logic [OUT*W-1:0] data, int done_edge);
    exp_t e;
    e.data = data;
    e.done_edge = done_edge;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_drain(string name, int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done in %0d cycles required done", name, budget);
      sb.delete();
    end
  endtask

  task automatic set_identity();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++)
        weights_in[(o*IN+i)*W +: W] = (i == o) ? 8'h10 : 8'h00;
    bias_in = '0;
  endtask

  task automatic set_mixed();
    for (int o = 0; o < OUT; o++)
      for (int i = 0; i < IN; i++)
        weights_in[(o*IN+i)*W +: W] = (i % 2 == 1) ? 8'hF0 : 8'h10;
    bias_in = '0;
  endtask

  int s, s2;

  initial begin
    rst = 1'b1; start = 1'b0; x_in = '0; weights_in = '0; bias_in = '0;
    weights_valid = 1'b0; bias_valid = 1'b0;
    tick(3);
    check_vec("reset_data_out", data_out, '0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    rst = 1'b0;
    tick(2);

    // Identity; x_in changes after start must not affect the run.
    set_identity();
    weights_valid = 1'b1; bias_valid = 1'b1;
    x_in = rep_in(8'h10);
    pulse_start(s);
    x_in = rep_in(8'h55);
    push_exp("identity", rep_out(8'h10), s + 81);
    tick(40);
    check_int("identity_busy_mid", int'(busy), 1);
    check_int("identity_done_mid", int'(done), 0);
    wait_drain("identity", 200);
    check_int("identity_busy_done", int'(busy), 0);

    // ReLU clamp: bias -1.0, zero weights.
    weights_in = '0;
    bias_in = rep_out(8'hF0);
    x_in = rep_in(8'h10);
    pulse_start(s);
    push_exp("relu", rep_out(8'h00), s + 81);
    wait_drain("relu", 200);

    // Mixed-sign weights cancel to zero.
    set_mixed();
    pulse_start(s);
    push_exp("mixed", rep_out(8'h00), s + 81);
    wait_drain("mixed", 200);

    // Saturation at full scale.
    x_in = rep_in(8'h7F);
    weights_in = '1;
    for (int k = 0; k < IN*OUT; k++) weights_in[k*W +: W] = 8'h7F;
    bias_in = rep_out(8'h7F);
    pulse_start(s);
    push_exp("saturate", rep_out(8'h7F), s + 81);
    wait_drain("saturate", 200);

    // Handshake: bias loader not ready for 10 cycles.
    set_identity();
    x_in = rep_in(8'h10);
    bias_valid = 1'b0;
    pulse_start(s);
    tick(10);
    check_int("wait_busy", int'(busy), 1);
    check_int("wait_done", int'(done), 0);
    check_vec("wait_data_held", data_out, rep_out(8'h7F));
    bias_valid = 1'b1;
    push_exp("handshake", rep_out(8'h10), cyc + 1 + 80);
    wait_drain("handshake", 200);

    // Reset during MAC of neuron 3; the aborted run must produce no done.
    pulse_start(s);
    tick(34);
    rst = 1'b1;
    tick(1);
    check_vec("midreset_data_out", data_out, '0);
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_done", int'(done), 0);
    rst = 1'b0;
    tick(1);
    pulse_start(s);
    push_exp("after_reset", rep_out(8'h10), s + 81);
    wait_drain("after_reset", 200);

    // start during MAC is ignored, even with a new x_in.
    pulse_start(s);
    push_exp("start_in_mac", rep_out(8'h10), s + 81);
    tick(19);
    x_in = rep_in(8'h20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_drain("start_in_mac", 200);

    // Restart from DONE with new activations.
    x_in = rep_in(8'h20);
    pulse_start(s2);
    check_int("restart_done_drop", int'(done), 0);
    check_int("restart_busy", int'(busy), 1);
    push_exp("restart", rep_out(8'h20), s2 + 81);
    wait_drain("restart", 200);
    check_int("final_done", int'(done), 1);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dense_layer_mac.md
Name: dense_layer_mac

Overview:
- Fully-connected layer compute stage. Sits directly downstream of the layer weight/bias BRAM loaders.
- Consumes their flat packed vectors, gated by the loaders' done flags, together with a packed input activation vector.
- Produces OUT_SIZE outputs, each signed-MAC'd, bias-added, ReLU'd and saturated.
- One shared multiplier handles one product per cycle. Outputs are computed sequentially by an FSM.

Parameters:
- IN_SIZE, 8, number of input activations.
- OUT_SIZE, 8, number of output neurons.
- W, 8, width of weights, bias, activations and outputs (signed two's complement, Q(W-FRAC).FRAC).
- FRAC, 4, fractional bits of the fixed-point format.
- ACC_W, 24, accumulator width (signed).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to compute the layer.
- x_in  input  IN_SIZE*W  packed activations; x[i] = x_in[i*W +: W].
- weights_in  input  IN_SIZE*OUT_SIZE*W  packed weights; w[o][i] = weights_in[(o*IN_SIZE+i)*W +: W].
- weights_valid  input  1  weight loader done flag.
- bias_in  input  OUT_SIZE*W  packed biases; b[o] = bias_in[o*W +: W].
- bias_valid  input  1  bias loader done flag.
- data_out  output  OUT_SIZE*W  packed results; y[o] at o*W.
- busy  output  1  high in any state other than IDLE/DONE.
- done  output  1  high while in DONE.

Behaviour:
- Reset: rst=1 at a posedge forces state=IDLE, data_out=0, done=0, busy=0, accumulator=0, counters=0, latched x=0. rst has priority over every other input, including mid-computation; the partial result is discarded.
- States: IDLE, WAIT, LOAD, MAC, WRITE, DONE.
- IDLE: when start=1, latch x_in into an internal register and go to WAIT. Later changes on x_in have no effect on the run.
- WAIT: stay until weights_valid && bias_valid are both high, then go to LOAD with o=0. There is no timeout.
- LOAD: acc <= sign_extend(b[o]) << FRAC; i <= 0; go to MAC.
- MAC: acc <= acc + sign_extend(x[i]*w[o][i]), using a full 2W-bit signed product. Runs for exactly IN_SIZE cycles; on i==IN_SIZE-1 go to WRITE.
- WRITE: r = acc >>> FRAC (arithmetic shift, floor).
  - y[o] <= 0 if r<0.
  - y[o] <= 2^(W-1)-1 if r > 2^(W-1)-1.
  - Otherwise y[o] <= r[W-1:0].
  - If o==OUT_SIZE-1 go to DONE; else o <= o+1 and go to LOAD.
- DONE: done=1 and data_out is held. When start=1, latch the new x_in and go to WAIT; done drops the next cycle.
- Earlier y[o] entries update one at a time during a run. Consumers read data_out only while done=1.
- start is ignored in WAIT, LOAD, MAC and WRITE.
- weights_in and bias_in are read directly, not copied; the loaders hold them stable after their done flag.
- If weights_valid or bias_valid drops after leaving WAIT, it is ignored.
- Latency: the posedge that samples start is edge 0. With both valids already high, done rises after edge OUT_SIZE*(IN_SIZE+2)+1, i.e. 81 edges for the defaults. Each cycle spent in WAIT adds one edge.
- ACC_W must be at least 2W+clog2(IN_SIZE)+1 and at least W+FRAC+1. No overflow handling inside the accumulator.

Test Plan:
1. Identity: FRAC=4, x[i]=16 (1.0), w[o][i]=16 if i==o else 0, b=0, valids high. Pulse start -> each y[o]=16; done=1 exactly 81 edges after start; busy high in between.
2. ReLU clamp: w=0, b[o]=0xF0 (-1.0) -> acc=-256, r=-16 -> every y[o]=0, done at edge 81.
3. Saturation: x[i]=127, w=127, b=127 -> acc=131064, r=8191 -> every y[o]=127. Separately, mixed-sign weights w[o][i]=(i odd?-16:16) with x=16 -> y[o]=0.
4. Handshake wait: start with bias_valid=0 for 10 cycles -> busy=1, done=0, data_out unchanged. Raise bias_valid -> done rises 80 edges after the edge it is sampled.
5. Reset mid-run: assert rst during MAC of o=3 (edge ~35) -> next cycle state IDLE, data_out=0, done=0, busy=0. A new start afterwards gives the correct result of scenario 1.
6. Start handling: pulse start again in MAC -> ignored, result and timing unchanged. Then in DONE, change x_in to all 32 and pulse start -> done=0 next cycle, then each y[o]=32 at edge 81.
